// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and select decode for the 1-to-4 stream demux
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry output holding slot with load/drain/full tracking
module demux_out_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  out_ready,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  can_load
);

    // A draining slot frees up at the same edge, so it may be refilled back-to-back.
    assign can_load = !full || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (out_ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - registered 1-to-4 stream demux; DEMUX_1TO4_STREAM_BROADCAST_EN adds Broadcast
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [SEL_W-1:0]      Select,
`ifdef DEMUX_1TO4_STREAM_BROADCAST_EN
    input  logic                  Broadcast,
`endif
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] C,
    output logic [DATA_WIDTH-1:0] D,
    output logic [NUM_CH-1:0]     Out_Valid,
    input  logic [NUM_CH-1:0]     Out_Ready
);

    logic [NUM_CH-1:0]     can_load;
    logic [NUM_CH-1:0]     target;
    logic [NUM_CH-1:0]     load_en;
    logic [DATA_WIDTH-1:0] slot_data [NUM_CH];

`ifdef DEMUX_1TO4_STREAM_BROADCAST_EN
    // A broadcast word waits until every slot can take it, so all copies land together.
    assign target   = Broadcast ? {NUM_CH{1'b1}} : sel_onehot(Select);
    assign In_Ready = Broadcast ? (&can_load) : can_load[Select];
`else
    assign target   = sel_onehot(Select);
    assign In_Ready = can_load[Select];
`endif

    assign load_en = target & {NUM_CH{In_Valid && In_Ready}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_out_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_en[k]),
            .load_data(In_Data),
            .out_ready(Out_Ready[k]),
            .full     (Out_Valid[k]),
            .data     (slot_data[k]),
            .can_load (can_load[k])
        );
    end

    assign A = slot_data[CH_A];
    assign B = slot_data[CH_B];
    assign C = slot_data[CH_C];
    assign D = slot_data[CH_D];

endmodule
